dcache_burst_controller: RTL and testbench

//  Parametrised write-back, write-allocate D-cache controller between pipeline, cache array and memory.

---
 rtl/dcache_burst_controller.sv | 176 +++++++++++++++++
 tb/tb_dcache_burst_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_burst_controller.sv
// Write-back, write-allocate D-cache controller with parametrised multi-beat refill and writeback.
// Hits complete in the request cycle; misses burst the victim out (if dirty), burst the line in, then fill.
module dcache_burst_controller #(
  parameter int ADDR_W      = 32,
  parameter int WORD_BYTES  = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int BEAT_WORDS  = 1,
  localparam int WB     = WORD_BYTES * 8,
  localparam int BLK_B  = BLOCK_WORDS * WB,
  localparam int BEAT_B = BEAT_WORDS * WB,
  localparam int NB     = WORD_BYTES * BLOCK_WORDS,
  localparam int OFF_W  = $clog2(NB),
  localparam int BA_W   = ADDR_W - OFF_W,
  localparam int BEATS  = BLOCK_WORDS / BEAT_WORDS,
  localparam int BI_W   = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ren,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_BYTES-1:0] byteSelectVector,
  input  logic [WB-1:0]     din,
  output logic              stall,
  output logic [WB-1:0]     dout,
  output logic [BA_W-1:0]   blockAddr,
  input  logic              cacheHit,
  input  logic              cacheDirtyBit,
  input  logic [BA_W-1:0]   cacheVictimAddr,
  input  logic [BLK_B-1:0]  cacheDout,
  output logic              cacheRen,
  output logic              cacheWen,
  output logic              cacheFillWen,
  output logic [NB-1:0]     cacheBytesAccess,
  output logic [BLK_B-1:0]  cacheDin,
  output logic              memRen,
  output logic              memWen,
  output logic [BA_W-1:0]   memAddr,
  output logic [BI_W-1:0]   memBeat,
  output logic [BEAT_B-1:0] memDin,
  input  logic              memReadReady,
  input  logic              memWriteDone,
  input  logic [BEAT_B-1:0] memDout
);

  // state | meaning
  // IDLE  | lookup; hits served combinationally, miss launches a transfer
  // WB    | writing dirty victim out, one beat per memWriteDone
  // RD    | reading missed line in, one beat per memReadReady
  // FILL  | one cycle writing the refilled (and store-merged) line to the array
  typedef enum logic [1:0] {S_IDLE, S_WB, S_RD, S_FILL} state_t;

  localparam int BO_W = $clog2(WORD_BYTES);
  localparam int WI_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  state_t            state, next_state;
  logic [BI_W-1:0]   beat;
  logic [BA_W-1:0]   victim_addr, miss_addr;
  logic [BLK_B-1:0]  fill_buf, fill_line, din_at_off;
  logic [NB-1:0]     store_mask;
  logic [WI_W-1:0]   word_idx;
  logic              req, last_beat, unused_ok;

  generate
    if (BLOCK_WORDS > 1) begin : g_widx
      assign word_idx = addr[BO_W +: WI_W];
    end else begin : g_widx1
      assign word_idx = '0;
    end
  endgenerate

  assign unused_ok = &{1'b0, addr};
  assign req       = ren ^ wen;
  assign last_beat = (beat == BI_W'(BEATS - 1));
  assign blockAddr = addr[ADDR_W-1:OFF_W];
  assign dout      = reset ? cacheDout[word_idx*WB +: WB] : '0;
  assign stall     = (state != S_IDLE) | (req & ~cacheHit);

  // Store word positioned in the line; the same view serves hit writes and the fill merge.
  always_comb begin
    store_mask = '0;
    din_at_off = '0;
    for (int w = 0; w < BLOCK_WORDS; w++) begin
      if (word_idx == WI_W'(w)) begin
        store_mask[w*WORD_BYTES +: WORD_BYTES] = byteSelectVector;
        din_at_off[w*WB +: WB] = din;
      end
    end
    fill_line = fill_buf;
    for (int i = 0; i < NB; i++) begin
      if (wen && store_mask[i]) fill_line[i*8 +: 8] = din_at_off[i*8 +: 8];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state       = state;
    cacheRen         = 1'b0;
    cacheWen         = 1'b0;
    cacheFillWen     = 1'b0;
    cacheBytesAccess = '0;
    cacheDin         = '0;
    memRen           = 1'b0;
    memWen           = 1'b0;
    memAddr          = '0;
    memBeat          = '0;
    memDin           = '0;
    case (state)
      S_IDLE: begin
        if (req && !cacheHit) begin
          next_state = cacheDirtyBit ? S_WB : S_RD;
        end else if (req && reset) begin
          cacheRen = ren;
          cacheWen = wen;
          if (wen) begin
            cacheBytesAccess = store_mask;
            cacheDin         = din_at_off;
          end
        end
      end
      S_WB: begin
        memWen  = 1'b1;
        memAddr = victim_addr;
        memBeat = beat;
        memDin  = cacheDout[beat*BEAT_B +: BEAT_B];
        if (memWriteDone && last_beat) next_state = S_RD;
      end
      S_RD: begin
        memRen  = 1'b1;
        memAddr = miss_addr;
        memBeat = beat;
        if (memReadReady && last_beat) next_state = S_FILL;
      end
      S_FILL: begin
        cacheFillWen = 1'b1;
        cacheDin     = fill_line;
        next_state   = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      beat        <= '0;
      victim_addr <= '0;
      miss_addr   <= '0;
      fill_buf    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req && !cacheHit) begin
            victim_addr <= cacheVictimAddr;
            miss_addr   <= blockAddr;
            beat        <= '0;
          end
        end
        S_WB: begin
          if (memWriteDone) beat <= last_beat ? '0 : beat + 1'b1;
        end
        S_RD: begin
          if (memReadReady) begin
            fill_buf[beat*BEAT_B +: BEAT_B] <= memDout;
            beat <= last_beat ? '0 : beat + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_burst_controller.sv
// Bench for dcache_burst_controller: a 4-beat and a 1-beat instance share pipeline/cache stimulus;
// a block-level memory model supplies refill data and predicts writeback beats and fill lines.
module tb_dcache_burst_controller;

  logic         clock = 1'b0;
  logic         reset;
  logic         sel;
  logic         ren, wen, cacheHit, cacheDirtyBit, memReadReady, memWriteDone;
  logic [31:0]  addr, din;
  logic [3:0]   bsv;
  logic [27:0]  cacheVictimAddr;
  logic [127:0] cacheDout, memDout;

  logic         stall_a, cren_a, cwen_a, cfill_a, mren_a, mwen_a;
  logic [31:0]  dout_a, mdin_a;
  logic [27:0]  ba_a, maddr_a;
  logic [15:0]  cbe_a;
  logic [127:0] cdin_a;
  logic [1:0]   mbeat_a;

  logic         stall_b, cren_b, cwen_b, cfill_b, mren_b, mwen_b, mbeat_b;
  logic [31:0]  dout_b;
  logic [27:0]  ba_b, maddr_b;
  logic [15:0]  cbe_b;
  logic [127:0] cdin_b, mdin_b;

  logic         o_stall, o_cren, o_cwen, o_cfill, o_mren, o_mwen;
  logic [31:0]  o_dout;
  logic [27:0]  o_ba, o_maddr;
  logic [15:0]  o_cbe;
  logic [127:0] o_cdin, o_mdin;
  logic [1:0]   o_beat;

  logic [127:0] mem [logic [27:0]];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  dcache_burst_controller #(.BEAT_WORDS(1)) u_a (
    .clock(clock), .reset(reset), .ren(ren), .wen(wen), .addr(addr),
    .byteSelectVector(bsv), .din(din), .stall(stall_a), .dout(dout_a), .blockAddr(ba_a),
    .cacheHit(cacheHit), .cacheDirtyBit(cacheDirtyBit), .cacheVictimAddr(cacheVictimAddr),
    .cacheDout(cacheDout), .cacheRen(cren_a), .cacheWen(cwen_a), .cacheFillWen(cfill_a),
    .cacheBytesAccess(cbe_a), .cacheDin(cdin_a), .memRen(mren_a), .memWen(mwen_a),
    .memAddr(maddr_a), .memBeat(mbeat_a), .memDin(mdin_a),
    .memReadReady(memReadReady & ~sel), .memWriteDone(memWriteDone & ~sel),
    .memDout(memDout[31:0]));

  dcache_burst_controller #(.BEAT_WORDS(4)) u_b (
    .clock(clock), .reset(reset), .ren(ren), .wen(wen), .addr(addr),
    .byteSelectVector(bsv), .din(din), .stall(stall_b), .dout(dout_b), .blockAddr(ba_b),
    .cacheHit(cacheHit), .cacheDirtyBit(cacheDirtyBit), .cacheVictimAddr(cacheVictimAddr),
    .cacheDout(cacheDout), .cacheRen(cren_b), .cacheWen(cwen_b), .cacheFillWen(cfill_b),
    .cacheBytesAccess(cbe_b), .cacheDin(cdin_b), .memRen(mren_b), .memWen(mwen_b),
    .memAddr(maddr_b), .memBeat(mbeat_b), .memDin(mdin_b),
    .memReadReady(memReadReady & sel), .memWriteDone(memWriteDone & sel),
    .memDout(memDout));

  assign o_stall = sel ? stall_b : stall_a;
  assign o_cren  = sel ? cren_b  : cren_a;
  assign o_cwen  = sel ? cwen_b  : cwen_a;
  assign o_cfill = sel ? cfill_b : cfill_a;
  assign o_mren  = sel ? mren_b  : mren_a;
  assign o_mwen  = sel ? mwen_b  : mwen_a;
  assign o_dout  = sel ? dout_b  : dout_a;
  assign o_ba    = sel ? ba_b    : ba_a;
  assign o_maddr = sel ? maddr_b : maddr_a;
  assign o_cbe   = sel ? cbe_b   : cbe_a;
  assign o_cdin  = sel ? cdin_b  : cdin_a;
  assign o_mdin  = sel ? mdin_b  : {96'b0, mdin_a};
  assign o_beat  = sel ? {1'b0, mbeat_b} : mbeat_a;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int n_beats();
    return sel ? 1 : 4;
  endfunction

  // Beat b of a block as memory sees it: 32-bit beats for u_a, whole block for u_b.
  function automatic logic [127:0] beat_of(input logic [127:0] line, input int b);
    if (sel) return line;
    return {96'b0, line[b*32 +: 32]};
  endfunction

  task automatic chk_bus(input bit is_wb, input logic [27:0] ba, input int b, input logic [127:0] data);
    check("bus_memWen", o_mwen, is_wb);
    check("bus_memRen", o_mren, !is_wb);
    check("bus_memAddr", o_maddr, ba);
    check("bus_memBeat", o_beat, b);
    check("bus_stall", o_stall, 1);
    if (is_wb) check("wb_memDin", o_mdin, data);
  endtask

  task automatic beat_phase(input bit is_wb, input logic [27:0] ba, input int b, input logic [127:0] data);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      @(negedge clock);
      memWriteDone = 0; memReadReady = 0;
      #1 chk_bus(is_wb, ba, b, data);
    end
    @(negedge clock);
    memWriteDone = 0; memReadReady = 0;
    if (is_wb) memWriteDone = 1;
    else begin memReadReady = 1; memDout = data; end
    #1 chk_bus(is_wb, ba, b, data);
  endtask

  task automatic txn(input bit r, input bit w, input logic [31:0] a, input logic [3:0] bs,
                     input logic [31:0] d, input bit hit, input bit dirty,
                     input logic [27:0] victim, input logic [127:0] line);
    logic [27:0]  blk;
    logic [127:0] blkdat, exp_line;
    int           word;
    bit           req;
    blk  = a[31:4];
    word = int'(a[3:2]);
    req  = r ^ w;
    @(negedge clock);
    ren = r; wen = w; addr = a; bsv = bs; din = d; cacheHit = hit;
    cacheDirtyBit = dirty; cacheVictimAddr = victim; cacheDout = line;
    #1;
    check("blockAddr", o_ba, blk);
    check("dout", o_dout, line[word*32 +: 32]);
    if (!req || hit) begin
      check("hit_stall", o_stall, 0);
      check("hit_cacheRen", o_cren, req & r);
      check("hit_cacheWen", o_cwen, req & w);
      check("hit_bytes", o_cbe, (req && w) ? (16'(bs) << (word * 4)) : 16'h0);
      if (req && w) check("hit_cacheDin", o_cdin, 128'(d) << (word * 32));
      @(negedge clock);
      #1 check("idle_no_mem", {o_mren, o_mwen, o_cfill}, 0);
    end else begin
      check("miss_stall", o_stall, 1);
      check("miss_strobes", {o_cren, o_cwen}, 0);
      if (dirty) begin
        for (int b = 0; b < n_beats(); b++) beat_phase(1'b1, victim, b, beat_of(line, b));
        mem[victim] = line;
      end
      if (!mem.exists(blk)) mem[blk] = rand128();
      blkdat = mem[blk];
      for (int b = 0; b < n_beats(); b++) beat_phase(1'b0, blk, b, beat_of(blkdat, b));
      exp_line = blkdat;
      if (w) for (int k = 0; k < 4; k++) if (bs[k]) exp_line[(word*4 + k)*8 +: 8] = d[k*8 +: 8];
      @(negedge clock);
      memReadReady = 0; memWriteDone = 0;
      #1;
      check("fill_wen", o_cfill, 1);
      check("fill_din", o_cdin, exp_line);
      check("fill_stall", o_stall, 1);
      check("fill_quiet", {o_mren, o_mwen, o_cren, o_cwen}, 0);
      @(negedge clock);
      cacheHit = 1; cacheDout = exp_line;
      #1;
      check("post_stall", o_stall, 0);
      check("post_fill", o_cfill, 0);
      check("post_dout", o_dout, exp_line[word*32 +: 32]);
      check("post_strobe", {o_cren, o_cwen}, {r, w});
    end
    @(negedge clock);
    ren = 0; wen = 0;
  endtask

  task automatic rand_txn();
    int kind;
    kind = $urandom_range(0, 5);
    txn(kind == 1 || kind == 3 || kind == 5, kind == 2 || kind == 3 || kind == 4,
        $urandom, 4'($urandom), $urandom, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
        28'($urandom), rand128());
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    reset = 1;
  endtask

  initial begin
    logic [127:0] line;
    reset = 0; sel = 0; ren = 1; wen = 0; addr = 32'h24; bsv = 0; din = 0;
    cacheHit = 1; cacheDirtyBit = 0; cacheVictimAddr = 0; cacheDout = rand128();
    memReadReady = 0; memWriteDone = 0; memDout = 0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_dout", o_dout, 0);
    check("rst_strobes", {o_cren, o_cwen, o_cfill, o_mren, o_mwen}, 0);
    check("rst_beat", o_beat, 0);
    @(negedge clock);
    reset = 1; ren = 0;

    line = 128'h44444444_33333333_DEADBEEF_11111111;
    txn(1, 0, 32'h24, 4'h0, 32'h0, 1, 0, 28'h0, line);
    txn(1, 0, 32'h1000, 4'h0, 32'h0, 0, 0, 28'h0, rand128());
    txn(0, 1, 32'h2008, 4'b0011, 32'hAABBCCDD, 0, 1, 28'h10, rand128());
    txn(1, 1, 32'h3000, 4'hF, 32'h12345678, 0, 1, 28'h77, rand128());
    txn(0, 1, 32'h2008, 4'b1001, 32'h01020304, 1, 0, 28'h0, rand128());

    // Abort a dirty writeback at beat 2; the next miss must start from beat 0.
    @(negedge clock);
    ren = 0; wen = 1; addr = 32'h5000; bsv = 4'hF; din = 32'h0; cacheHit = 0;
    cacheDirtyBit = 1; cacheVictimAddr = 28'h0ABC; cacheDout = rand128();
    beat_phase(1'b1, 28'h0ABC, 0, beat_of(cacheDout, 0));
    beat_phase(1'b1, 28'h0ABC, 1, beat_of(cacheDout, 1));
    @(negedge clock);
    memWriteDone = 0;
    #1 check("abort_beat2", o_beat, 2);
    #2 reset = 0;
    #1;
    check("abort_memWen", o_mwen, 0);
    check("abort_beat", o_beat, 0);
    check("abort_dout", o_dout, 0);
    check("abort_stall", o_stall, 1);
    @(negedge clock);
    reset = 1; wen = 0;
    txn(0, 1, 32'h5004, 4'hC, 32'hCAFEF00D, 0, 1, 28'h0ABC, rand128());

    for (int i = 0; i < 30; i++) rand_txn();

    pulse_reset();
    sel = 1;
    txn(1, 0, 32'h8010, 4'h0, 32'h0, 0, 1, 28'h321, rand128());
    txn(0, 1, 32'h900C, 4'b0110, 32'h5566_7788, 0, 0, 28'h0, rand128());
    for (int i = 0; i < 15; i++) rand_txn();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
